// File: rtl/alu_exec_unit_if.sv
//============================================================================
// Module      : alu_exec_unit_if
// Description : Dispatch and update bus bundle for the integer ALU unit.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef ALU_EXEC_WIDTHS_DEFINED
`define ALU_EXEC_WIDTHS_DEFINED
`define DATA_WIDTH          32
`define ROB_TAG_WIDTH       5
`define INSIDE_OPCODE_WIDTH 6
`define ZERO_ROB_TAG        5'd0
`endif

interface alu_exec_unit_if;
    logic                            rdy;
    logic [`INSIDE_OPCODE_WIDTH-1:0] in_rs_op;
    logic [`DATA_WIDTH-1:0]          in_rs_value_rs1;
    logic [`DATA_WIDTH-1:0]          in_rs_value_rs2;
    logic [`DATA_WIDTH-1:0]          in_rs_imm;
    logic [`DATA_WIDTH-1:0]          in_rs_pc;
    logic [`ROB_TAG_WIDTH-1:0]       in_rs_reorder;
    logic                            in_alu_misbranch;
    logic                            in_cdb_grant;
    logic [`ROB_TAG_WIDTH-1:0]       out_update_reorder;
    logic [`DATA_WIDTH-1:0]          out_update_value;
    logic                            out_update_jump;
    logic [`DATA_WIDTH-1:0]          out_update_target;
    logic                            out_rs_busy;

    modport master (
        output rdy, in_rs_op, in_rs_value_rs1, in_rs_value_rs2, in_rs_imm,
               in_rs_pc, in_rs_reorder, in_alu_misbranch, in_cdb_grant,
        input  out_update_reorder, out_update_value, out_update_jump,
               out_update_target, out_rs_busy
    );

    modport slave (
        input  rdy, in_rs_op, in_rs_value_rs1, in_rs_value_rs2, in_rs_imm,
               in_rs_pc, in_rs_reorder, in_alu_misbranch, in_cdb_grant,
        output out_update_reorder, out_update_value, out_update_jump,
               out_update_target, out_rs_busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
//============================================================================
// Module      : alu_exec_unit
// Description : One-cycle RV32I ALU/branch/jump unit with a result FIFO.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef ALU_EXEC_WIDTHS_DEFINED
`define ALU_EXEC_WIDTHS_DEFINED
`define DATA_WIDTH          32
`define ROB_TAG_WIDTH       5
`define INSIDE_OPCODE_WIDTH 6
`define ZERO_ROB_TAG        5'd0
`endif

`ifndef ALU_EXEC_OPCODES_DEFINED
`define ALU_EXEC_OPCODES_DEFINED
`define NOP       6'd0
`define OP_LUI    6'd1
`define OP_AUIPC  6'd2
`define OP_JAL    6'd3
`define OP_JALR   6'd4
`define OP_BEQ    6'd5
`define OP_BNE    6'd6
`define OP_BLT    6'd7
`define OP_BGE    6'd8
`define OP_BLTU   6'd9
`define OP_BGEU   6'd10
`define OP_ADDI   6'd11
`define OP_SLTI   6'd12
`define OP_SLTIU  6'd13
`define OP_XORI   6'd14
`define OP_ORI    6'd15
`define OP_ANDI   6'd16
`define OP_SLLI   6'd17
`define OP_SRLI   6'd18
`define OP_SRAI   6'd19
`define OP_ADD    6'd20
`define OP_SUB    6'd21
`define OP_SLL    6'd22
`define OP_SLT    6'd23
`define OP_SLTU   6'd24
`define OP_XOR    6'd25
`define OP_SRL    6'd26
`define OP_SRA    6'd27
`define OP_OR     6'd28
`define OP_AND    6'd29
`endif

module alu_exec_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_LEVEL = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

    // FIFO_DEPTH is a power of two, so pointers wrap naturally
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [`ROB_TAG_WIDTH-1:0] reorder;
        logic [`DATA_WIDTH-1:0]    value;
        logic                      jump;
        logic [`DATA_WIDTH-1:0]    target;
    } result_t;

    localparam result_t c_IDLE = '{reorder: `ZERO_ROB_TAG, value: '0,
                                   jump: 1'b0, target: '0};

    result_t              r_mem [FIFO_DEPTH];
    result_t              r_out;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic [`DATA_WIDTH-1:0] w_a;
    logic [`DATA_WIDTH-1:0] w_b;
    logic [`DATA_WIDTH-1:0] w_pc_plus4;
    logic [`DATA_WIDTH-1:0] w_pc_imm;
    logic                   w_is_imm;
    logic                   w_is_branch;
    logic                   w_taken;
    result_t                w_result;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_bypass;
    logic w_push_req;
    logic w_push;

    always_comb begin
        w_a         = bus.in_rs_value_rs1;
        w_is_imm    = (bus.in_rs_op >= `OP_ADDI) && (bus.in_rs_op <= `OP_SRAI);
        w_is_branch = (bus.in_rs_op >= `OP_BEQ)  && (bus.in_rs_op <= `OP_BGEU);
        w_b         = w_is_imm ? bus.in_rs_imm : bus.in_rs_value_rs2;
        w_pc_plus4  = bus.in_rs_pc + `DATA_WIDTH'(4);
        w_pc_imm    = bus.in_rs_pc + bus.in_rs_imm;
        w_taken     = 1'b0;

        w_result.reorder = bus.in_rs_reorder;
        w_result.value   = '0;
        w_result.jump    = 1'b0;
        w_result.target  = w_pc_plus4;

        case (bus.in_rs_op)
            `OP_ADD,  `OP_ADDI:  w_result.value = w_a + w_b;
            `OP_SUB:             w_result.value = w_a - w_b;
            `OP_AND,  `OP_ANDI:  w_result.value = w_a & w_b;
            `OP_OR,   `OP_ORI:   w_result.value = w_a | w_b;
            `OP_XOR,  `OP_XORI:  w_result.value = w_a ^ w_b;
            `OP_SLT,  `OP_SLTI:
                w_result.value = {{(`DATA_WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            `OP_SLTU, `OP_SLTIU:
                w_result.value = {{(`DATA_WIDTH-1){1'b0}}, w_a < w_b};
            `OP_SLL,  `OP_SLLI:  w_result.value = w_a << w_b[4:0];
            `OP_SRL,  `OP_SRLI:  w_result.value = w_a >> w_b[4:0];
            `OP_SRA,  `OP_SRAI:  w_result.value = $unsigned($signed(w_a) >>> w_b[4:0]);
            `OP_LUI:             w_result.value = bus.in_rs_imm;
            `OP_AUIPC:           w_result.value = w_pc_imm;
            `OP_JAL: begin
                w_result.value = w_pc_plus4;
                w_taken        = 1'b1;
            end
            `OP_JALR: begin
                w_result.value  = w_pc_plus4;
                w_result.jump   = 1'b1;
                w_result.target = (w_a + bus.in_rs_imm) & ~`DATA_WIDTH'(1);
            end
            `OP_BEQ:  w_taken = (w_a == w_b);
            `OP_BNE:  w_taken = (w_a != w_b);
            `OP_BLT:  w_taken = ($signed(w_a) <  $signed(w_b));
            `OP_BGE:  w_taken = ($signed(w_a) >= $signed(w_b));
            `OP_BLTU: w_taken = (w_a <  w_b);
            `OP_BGEU: w_taken = (w_a >= w_b);
            default: ;
        endcase

        // JAL and taken branches share the pc-relative target path
        if (w_taken) begin
            w_result.jump   = 1'b1;
            w_result.target = w_pc_imm;
        end
        if (w_is_branch) begin
            w_result.value = '0;
        end
    end

    assign w_valid    = (bus.in_rs_op != `NOP) && (bus.in_rs_reorder != `ZERO_ROB_TAG);
    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop      = bus.in_cdb_grant && (r_count != '0);
    assign w_bypass   = bus.in_cdb_grant && (r_count == '0) && w_valid;
    assign w_push_req = w_valid && !w_bypass;
    assign w_push     = w_push_req && !w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out   <= c_IDLE;
        end else if (bus.rdy) begin
            if (bus.in_alu_misbranch) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_out   <= c_IDLE;
            end else begin
                r_out <= c_IDLE;
                if (w_pop) begin
                    r_out  <= r_mem[r_head];
                    r_head <= r_head + c_PTR_W'(1);
                end else if (w_bypass) begin
                    r_out <= w_result;
                end
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && !bus.in_alu_misbranch && w_push) begin
            r_mem[r_tail] <= w_result;
        end
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        (bus.rdy && !bus.in_alu_misbranch && w_push_req) |-> !w_full
    ) else $error("alu_exec_unit: result FIFO overflow, op dropped");

    assign bus.out_update_reorder = r_out.reorder;
    assign bus.out_update_value   = r_out.value;
    assign bus.out_update_jump    = r_out.jump;
    assign bus.out_update_target  = r_out.target;
    assign bus.out_rs_busy        = (r_count >= c_CNT_W'(BUSY_LEVEL));

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
//============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed and random checks of alu_exec_unit against a model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef ALU_EXEC_WIDTHS_DEFINED
`define ALU_EXEC_WIDTHS_DEFINED
`define DATA_WIDTH          32
`define ROB_TAG_WIDTH       5
`define INSIDE_OPCODE_WIDTH 6
`define ZERO_ROB_TAG        5'd0
`endif

`ifndef ALU_EXEC_OPCODES_DEFINED
`define ALU_EXEC_OPCODES_DEFINED
`define NOP       6'd0
`define OP_LUI    6'd1
`define OP_AUIPC  6'd2
`define OP_JAL    6'd3
`define OP_JALR   6'd4
`define OP_BEQ    6'd5
`define OP_BNE    6'd6
`define OP_BLT    6'd7
`define OP_BGE    6'd8
`define OP_BLTU   6'd9
`define OP_BGEU   6'd10
`define OP_ADDI   6'd11
`define OP_SLTI   6'd12
`define OP_SLTIU  6'd13
`define OP_XORI   6'd14
`define OP_ORI    6'd15
`define OP_ANDI   6'd16
`define OP_SLLI   6'd17
`define OP_SRLI   6'd18
`define OP_SRAI   6'd19
`define OP_ADD    6'd20
`define OP_SUB    6'd21
`define OP_SLL    6'd22
`define OP_SLT    6'd23
`define OP_SLTU   6'd24
`define OP_XOR    6'd25
`define OP_SRL    6'd26
`define OP_SRA    6'd27
`define OP_OR     6'd28
`define OP_AND    6'd29
`endif

module tb_alu_exec_unit;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] val;
        logic        jump;
        logic [31:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t mq[$];
    exp_t eo;

    always #5 clk = ~clk;

    alu_exec_unit_if bus();

    alu_exec_unit #(.FIFO_DEPTH(4), .BUSY_LEVEL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic exp_t ref_exec(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] r2, input logic [31:0] imm,
                                      input logic [31:0] pc, input logic [4:0] tag);
        exp_t        r;
        logic [31:0] b;
        int          sa, sb;
        b  = (op >= `OP_ADDI && op <= `OP_SRAI) ? imm : r2;
        sa = a;
        sb = b;
        r.tag = tag; r.val = 0; r.jump = 0; r.tgt = pc + 4;
        case (op)
            `OP_ADD,  `OP_ADDI:  r.val = a + b;
            `OP_SUB:             r.val = a - b;
            `OP_AND,  `OP_ANDI:  r.val = a & b;
            `OP_OR,   `OP_ORI:   r.val = a | b;
            `OP_XOR,  `OP_XORI:  r.val = a ^ b;
            `OP_SLT,  `OP_SLTI:  r.val = (sa < sb) ? 32'd1 : 32'd0;
            `OP_SLTU, `OP_SLTIU: r.val = (a < b) ? 32'd1 : 32'd0;
            `OP_SLL,  `OP_SLLI:  r.val = a << b[4:0];
            `OP_SRL,  `OP_SRLI:  r.val = a >> b[4:0];
            `OP_SRA,  `OP_SRAI:  r.val = 32'(sa >>> b[4:0]);
            `OP_LUI:   r.val = imm;
            `OP_AUIPC: r.val = pc + imm;
            `OP_JAL:  begin r.val = pc + 4; r.jump = 1; r.tgt = pc + imm; end
            `OP_JALR: begin r.val = pc + 4; r.jump = 1; r.tgt = (a + imm) & 32'hFFFF_FFFE; end
            `OP_BEQ:  r.jump = (a == b);
            `OP_BNE:  r.jump = (a != b);
            `OP_BLT:  r.jump = (sa < sb);
            `OP_BGE:  r.jump = (sa >= sb);
            `OP_BLTU: r.jump = (a < b);
            `OP_BGEU: r.jump = (a >= b);
            default: ;
        endcase
        if (op >= `OP_BEQ && op <= `OP_BGEU && r.jump) r.tgt = pc + imm;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", name, obs, exp);
        end
    endtask

    // Model of one clock edge, evaluated from the inputs present at that edge
    task automatic model_edge();
        exp_t e;
        logic valid;
        logic used;
        if (rst) begin
            mq.delete();
            eo = '0;
        end else if (bus.rdy) begin
            if (bus.in_alu_misbranch) begin
                mq.delete();
                eo = '0;
            end else begin
                valid = (bus.in_rs_op != `NOP) && (bus.in_rs_reorder != 0);
                e = ref_exec(bus.in_rs_op, bus.in_rs_value_rs1, bus.in_rs_value_rs2,
                             bus.in_rs_imm, bus.in_rs_pc, bus.in_rs_reorder);
                used = 0;
                eo = '0;
                if (bus.in_cdb_grant && mq.size() > 0) begin
                    eo = mq.pop_front();
                end else if (bus.in_cdb_grant && valid) begin
                    eo = e;
                    used = 1;
                end
                if (valid && !used && mq.size() < 4) mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("tag", 32'(bus.out_update_reorder), 32'(eo.tag));
        if (eo.tag != 0) begin
            chk("value",  bus.out_update_value,        eo.val);
            chk("jump",   32'(bus.out_update_jump),    32'(eo.jump));
            chk("target", bus.out_update_target,       eo.tgt);
        end
        chk("busy", 32'(bus.out_rs_busy), 32'(mq.size() >= 2));
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
        bus.in_rs_op        = op;
        bus.in_rs_value_rs1 = a;
        bus.in_rs_value_rs2 = b;
        bus.in_rs_imm       = imm;
        bus.in_rs_pc        = pc;
        bus.in_rs_reorder   = tag;
    endtask

    task automatic no_op();
        disp(`NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.in_alu_misbranch = 1'b0;
        bus.in_cdb_grant = 1'b0;
        no_op();
        mq.delete();
        eo = '0;
        #12;
        chk("rst_tag",    32'(bus.out_update_reorder), 32'd0);
        chk("rst_value",  bus.out_update_value,        32'd0);
        chk("rst_jump",   32'(bus.out_update_jump),    32'd0);
        chk("rst_target", bus.out_update_target,       32'd0);
        chk("rst_busy",   32'(bus.out_rs_busy),        32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD bypass
        bus.in_cdb_grant = 1'b1;
        disp(`OP_ADD, 32'd5, 32'd7, 32'd0, 32'h200, 5'd3);
        tick();
        chk("add_tag", 32'(bus.out_update_reorder), 32'd3);
        chk("add_val", bus.out_update_value, 32'd12);
        chk("add_tgt", bus.out_update_target, 32'h204);
        no_op();
        tick();
        chk("add_idle", 32'(bus.out_update_reorder), 32'd0);

        // signed vs unsigned branch
        disp(`OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd4);
        tick();
        chk("blt_jump", 32'(bus.out_update_jump), 32'd1);
        chk("blt_tgt",  bus.out_update_target, 32'h120);
        disp(`OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5);
        tick();
        chk("bltu_jump", 32'(bus.out_update_jump), 32'd0);
        chk("bltu_tgt",  bus.out_update_target, 32'h104);

        disp(`OP_JALR, 32'h1001, 32'd0, 32'd4, 32'h40, 5'd7);
        tick();
        chk("jalr_val", bus.out_update_value, 32'h44);
        chk("jalr_tgt", bus.out_update_target, 32'h1004);
        disp(`OP_SRA, 32'h8000_0000, 32'd33, 32'd0, 32'h50, 5'd8);
        tick();
        chk("sra_val", bus.out_update_value, 32'hC000_0000);
        no_op();
        tick();

        // Queue three results with grant low, then drain
        bus.in_cdb_grant = 1'b0;
        disp(`OP_ADDI, 32'd10, 32'd0, 32'd1, 32'h300, 5'd1);
        tick();
        chk("busy_after1", 32'(bus.out_rs_busy), 32'd0);
        disp(`OP_ADDI, 32'd20, 32'd0, 32'd2, 32'h304, 5'd2);
        tick();
        chk("busy_after2", 32'(bus.out_rs_busy), 32'd1);
        disp(`OP_ADDI, 32'd30, 32'd0, 32'd3, 32'h308, 5'd3);
        tick();
        no_op();
        bus.in_cdb_grant = 1'b1;
        tick();
        chk("drain1", 32'(bus.out_update_reorder), 32'd1);
        tick();
        chk("drain2", 32'(bus.out_update_reorder), 32'd2);
        tick();
        chk("drain3", 32'(bus.out_update_reorder), 32'd3);
        chk("drain_busy", 32'(bus.out_rs_busy), 32'd0);
        tick();

        // Misbranch with two queued results and an incoming op
        bus.in_cdb_grant = 1'b0;
        disp(`OP_XOR, 32'hF0, 32'h0F, 32'd0, 32'h400, 5'd4);
        tick();
        disp(`OP_OR, 32'hF0, 32'h0F, 32'd0, 32'h404, 5'd5);
        tick();
        disp(`OP_AND, 32'hFF, 32'h0F, 32'd0, 32'h408, 5'd6);
        bus.in_alu_misbranch = 1'b1;
        tick();
        chk("mis_tag",  32'(bus.out_update_reorder), 32'd0);
        chk("mis_busy", 32'(bus.out_rs_busy), 32'd0);
        bus.in_alu_misbranch = 1'b0;
        no_op();
        bus.in_cdb_grant = 1'b1;
        repeat (3) tick();

        // rdy low freezes an active broadcast and the queue
        bus.in_cdb_grant = 1'b0;
        disp(`OP_LUI, 32'd0, 32'd0, 32'hABCD_E000, 32'h500, 5'd10);
        tick();
        bus.in_cdb_grant = 1'b1;
        disp(`OP_AUIPC, 32'd0, 32'd0, 32'h1000, 32'h504, 5'd11);
        tick();
        bus.rdy = 1'b0;
        disp(`OP_SUB, 32'd9, 32'd4, 32'd0, 32'h508, 5'd12);
        repeat (3) begin
            tick();
            chk("frz_tag", 32'(bus.out_update_reorder), 32'd10);
            chk("frz_val", bus.out_update_value, 32'hABCD_E000);
        end
        bus.rdy = 1'b1;
        no_op();
        tick();
        chk("thaw_tag", 32'(bus.out_update_reorder), 32'd11);
        tick();

        // Async reset between edges during a broadcast
        bus.in_cdb_grant = 1'b0;
        disp(`OP_SLT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'h600, 5'd13);
        tick();
        bus.in_cdb_grant = 1'b1;
        disp(`OP_SLTU, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'h604, 5'd14);
        tick();
        no_op();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tag",  32'(bus.out_update_reorder), 32'd0);
        chk("arst_busy", 32'(bus.out_rs_busy), 32'd0);
        mq.delete();
        eo = '0;
        #1;
        rst = 1'b0;
        tick();

        // Randomized traffic honouring the busy throttle
        for (int i = 0; i < 400; i++) begin
            bus.rdy              = ($urandom_range(0, 9) != 0);
            bus.in_alu_misbranch = ($urandom_range(0, 19) == 0);
            bus.in_cdb_grant     = ($urandom_range(0, 9) < 6);
            if (mq.size() >= 2) begin
                no_op();
            end else begin
                disp(6'($urandom_range(0, 29)),
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom,
                     $urandom & 32'hFFFF_FFFC,
                     5'($urandom_range(0, 31)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
